regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
Sequencer that initiates the register file's read/write accesses. It accepts one micro-op per command handshake and drives the two read addresses. It waits the register file's read latency, computes a 3-bit result, optionally writes it back through the write port, and returns the result on a valid/ready result channel. It sits between the exp-series control unit and the register file.

Parameters:
DATA_W, 3, register data width
ADDR_W, 2, register index width
NUM_REGS, 3, number of implemented registers; indices >= NUM_REGS are illegal
RD_LAT, 1, cycles from read address driven to rf_reg_data valid (1..4)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept command
cmd_op  in  2  00 MOV(rs1), 01 ADD, 10 SUB(rs1-rs2), 11 AND
cmd_rs1  in  ADDR_W  source register 1
cmd_rs2  in  ADDR_W  source register 2
cmd_rd  in  ADDR_W  destination register
cmd_we  in  1  1 = write result back to cmd_rd
rf_rd_reg1  out  ADDR_W  register file read address 1
rf_rd_reg2  out  ADDR_W  register file read address 2
rf_wr_reg  out  ADDR_W  register file write address
rf_wr_data  out  DATA_W  register file write data
rf_wr_en  out  1  register file write enable
rf_reg_data1  in  DATA_W  read data 1
rf_reg_data2  in  DATA_W  read data 2
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  DATA_W  operation result
res_err  out  1  command had an illegal register index
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: state IDLE, cmd_ready=1, res_valid=0, res_data=0, res_err=0, rf_wr_en=0, rf_rd_reg1/2=0, rf_wr_reg=0, rf_wr_data=0, busy=0, wait counter=0. Reset mid-operation aborts the op. No write is issued in the reset cycle or the cycle after it.
- FSM states: IDLE, READ, EXEC, WB, RESP.
- IDLE: cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op, rs1, rs2, rd and we.
  - Drive rf_rd_reg1=rs1 and rf_rd_reg2=rs2 from the next cycle; load counter with RD_LAT; go to READ.
  - If any index >= NUM_REGS: set err, skip READ/EXEC/WB, go to RESP with res_data=0 and res_err=1.
- READ: cmd_ready=0; read addresses held stable. The counter decrements each cycle; when it reaches 1, capture rf_reg_data1/2 into operand registers and go to EXEC. Minimum READ dwell = RD_LAT cycles.
- EXEC: compute result modulo 2^DATA_W.
  - MOV = op1; ADD = op1+op2 with carry dropped; SUB = op1-op2, two's-complement wrap; AND = op1&op2.
  - Register the result into res_data. If we=1 go to WB, else go to RESP.
- WB: rf_wr_en=1 for exactly one cycle, with rf_wr_reg=rd and rf_wr_data=result stable in that same cycle; go to RESP.
- RESP: res_valid=1; res_data and res_err held. Leave to IDLE on res_valid&res_ready; res_valid drops the following cycle.
- Back-to-back: a new command is accepted no earlier than the cycle after RESP handshake (cmd_ready is 1 only in IDLE).
- Hazards: a write-back completes before the next command's reads, so a read-after-write to the same register returns the new value.
- rf_wr_en=0 in every state except WB, including the error path.
- busy = (state != IDLE).
- Latency cmd accept -> res_valid: 2+RD_LAT cycles without write-back, 3+RD_LAT with write-back, 1 cycle on error.

Test Plan:
- Reset then idle: rst high 2 cycles -> cmd_ready=1, res_valid=0, rf_wr_en=0, busy=0; all addresses and data 0.
- ADD with writeback: regs {3,5,1}, op=01, rs1=0, rs2=1, rd=2, we=1, RD_LAT=1 -> one cycle rf_wr_en=1, rf_wr_reg=2, rf_wr_data=0 (3+5=8 wraps); res_data=0, res_err=0, res_valid 4 cycles after accept.
- SUB wrap, no writeback: regs {1,2,x}, op=10, rs1=0, rs2=1, we=0 -> res_data=7; rf_wr_en never asserted; res_valid 3 cycles after accept.
- Illegal index: rs2=3 -> res_err=1, res_data=0, rf_wr_en stays 0, res_valid one cycle after accept.
- Backpressure / RAW:
  - Hold res_ready=0 for 5 cycles -> res_valid and res_data stable, cmd_ready=0.
  - Then MOV rd=1 from reg0 (we=1), followed by AND rs1=1, rs2=1 -> second result equals reg0's value.
- Reset mid-op: assert rst during READ -> next cycle IDLE, no rf_wr_en pulse, res_valid=0.

Source files
------------

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: micro-op sequencer driving register file reads, a small ALU and write-back,
// returning each result on a valid/ready channel.
module regfile_ctrl #(
  parameter int DATA_W   = 3,
  parameter int ADDR_W   = 2,
  parameter int NUM_REGS = 3,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic              cmd_we,
  output logic [ADDR_W-1:0] rf_rd_reg1,
  output logic [ADDR_W-1:0] rf_rd_reg2,
  output logic [ADDR_W-1:0] rf_wr_reg,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wr_en,
  input  logic [DATA_W-1:0] rf_reg_data1,
  input  logic [DATA_W-1:0] rf_reg_data2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_t;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);
  state_t            r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic              r_we;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] w_res;
  logic              w_bad;
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  // rd is checked even when the write is disabled: the whole command is rejected
  assign w_bad = ({1'b0, cmd_rs1} >= LIM) || ({1'b0, cmd_rs2} >= LIM) || ({1'b0, cmd_rd} >= LIM);
  always_comb begin
    w_res = (r_op == 2'b00) ? r_op1 :
            (r_op == 2'b01) ? r_op1 + r_op2 :
            (r_op == 2'b10) ? r_op1 - r_op2 : r_op1 & r_op2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_cnt      <= '0;
      rf_rd_reg1 <= '0;
      rf_rd_reg2 <= '0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
      rf_wr_en   <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_op       <= cmd_op;
          r_rd       <= cmd_rd;
          r_we       <= cmd_we;
          rf_rd_reg1 <= cmd_rs1;
          rf_rd_reg2 <= cmd_rs2;
          r_cnt      <= 3'(RD_LAT);
          res_data   <= '0;
          res_err    <= w_bad;
          res_valid  <= w_bad;
          r_state    <= w_bad ? RESP : READ;
        end
        READ: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_op1   <= rf_reg_data1;
            r_op2   <= rf_reg_data2;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          res_data   <= w_res;
          rf_wr_reg  <= r_rd;
          rf_wr_data <= w_res;
          rf_wr_en   <= r_we;
          res_valid  <= !r_we;
          r_state    <= r_we ? WB : RESP;
        end
        WB: begin
          rf_wr_en  <= 1'b0;
          res_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (res_ready) begin
          res_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: directed vector table plus hand sequences for backpressure, RAW and reset abort.
module tb_regfile_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [1:0] cmd_rs1 = '0;
  logic [1:0] cmd_rs2 = '0;
  logic [1:0] cmd_rd = '0;
  logic       cmd_we = 1'b0;
  logic [1:0] rf_rd_reg1;
  logic [1:0] rf_rd_reg2;
  logic [1:0] rf_wr_reg;
  logic [2:0] rf_wr_data;
  logic       rf_wr_en;
  logic [2:0] rf_reg_data1;
  logic [2:0] rf_reg_data2;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [2:0] res_data;
  logic       res_err;
  logic       busy;
  logic [2:0] rf [4];
  int         wr_cnt = 0;
  int         wr_reg_l = 0;
  int         wr_data_l = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  typedef struct {
    int op; int rs1; int rs2; int rd; int we;
    int r0; int r1; int r2;
    int d; int e; int lat;
  } vec_t;
  vec_t v [9];
  regfile_ctrl #(.DATA_W(3), .ADDR_W(2), .NUM_REGS(3), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_we(cmd_we),
    .rf_rd_reg1(rf_rd_reg1), .rf_rd_reg2(rf_rd_reg2),
    .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en),
    .rf_reg_data1(rf_reg_data1), .rf_reg_data2(rf_reg_data2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );
  always #5 clk = ~clk;
  assign rf_reg_data1 = rf[rf_rd_reg1];
  assign rf_reg_data2 = rf[rf_rd_reg2];
  always @(posedge clk) begin
    if (rf_wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      wr_reg_l  <= int'(rf_wr_reg);
      wr_data_l <= int'(rf_wr_data);
      rf[rf_wr_reg] <= rf_wr_data;
    end
  end
  function automatic void chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  task automatic load(input vec_t x);
    rf[0] = 3'(x.r0);
    rf[1] = 3'(x.r1);
    rf[2] = 3'(x.r2);
  endtask
  task automatic run(input vec_t x, input int hold);
    int lat;
    int w0;
    bit wb;
    wb = (x.we != 0) && (x.e == 0);
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    w0 = wr_cnt;
    cmd_valid = 1'b1;
    cmd_op = 2'(x.op);
    cmd_rs1 = 2'(x.rs1);
    cmd_rs2 = 2'(x.rs2);
    cmd_rd = 2'(x.rd);
    cmd_we = x.we[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    chk("busy_after_accept", int'(busy), 1);
    if (x.e == 0) begin
      chk("rd_reg1", int'(rf_rd_reg1), x.rs1);
      chk("rd_reg2", int'(rf_rd_reg2), x.rs2);
    end
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, x.lat);
    chk("res_data", int'(res_data), x.d);
    chk("res_err", int'(res_err), x.e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_data", int'(res_data), x.d);
      chk("hold_cmd_ready", int'(cmd_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("valid_drop", int'(res_valid), 0);
    chk("busy_drop", int'(busy), 0);
    chk("wr_pulses", wr_cnt - w0, wb ? 1 : 0);
    if (wb) begin
      chk("wr_reg", wr_reg_l, x.rd);
      chk("wr_data", wr_data_l, x.d);
    end
  endtask
  initial begin
    vec_t a;
    int w0;
    //        op rs1 rs2 rd we  r0 r1 r2  d  e lat
    v[0] = '{1, 0, 1, 2, 1,  3, 5, 1,  0, 0, 4};
    v[1] = '{2, 0, 1, 2, 0,  1, 2, 0,  7, 0, 3};
    v[2] = '{1, 0, 3, 0, 1,  1, 2, 3,  0, 1, 1};
    v[3] = '{3, 0, 1, 0, 1,  6, 3, 0,  2, 0, 4};
    v[4] = '{0, 2, 0, 1, 0,  1, 1, 5,  5, 0, 3};
    v[5] = '{1, 1, 2, 1, 1,  0, 7, 7,  6, 0, 4};
    v[6] = '{2, 2, 2, 0, 0,  3, 3, 4,  0, 0, 3};
    v[7] = '{0, 0, 1, 3, 0,  2, 2, 2,  0, 1, 1};
    v[8] = '{3, 3, 0, 1, 1,  7, 7, 7,  0, 1, 1};
    for (int i = 0; i < 4; i++) rf[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_wr_en", int'(rf_wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_reg1", int'(rf_rd_reg1), 0);
    chk("rst_rd_reg2", int'(rf_rd_reg2), 0);
    chk("rst_wr_reg", int'(rf_wr_reg), 0);
    chk("rst_wr_data", int'(rf_wr_data), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_err", int'(res_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      load(v[i]);
      run(v[i], 0);
    end
    // backpressure: result held for 5 cycles with res_ready low
    a = '{1, 0, 1, 2, 0, 3, 2, 0, 5, 0, 3};
    load(a);
    run(a, 5);
    // RAW: MOV reg0 -> reg1, then AND reg1,reg1 issued right after the handshake
    a = '{0, 0, 2, 1, 1, 5, 0, 2, 5, 0, 4};
    load(a);
    run(a, 0);
    chk("raw_model_reg1", int'(rf[1]), 5);
    a = '{3, 1, 1, 0, 0, 0, 0, 0, 5, 0, 3};
    run(a, 0);
    // reset during READ aborts the op with no write pulse
    a = '{1, 0, 1, 2, 1, 3, 5, 1, 0, 0, 4};
    load(a);
    w0 = wr_cnt;
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_rs1 = 2'd0;
    cmd_rs2 = 2'd1;
    cmd_rd = 2'd2;
    cmd_we = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("abort_in_read", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    chk("abort_res_valid", int'(res_valid), 0);
    chk("abort_wr_en", int'(rf_wr_en), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_still_idle", int'(res_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
